universal_mux_register: RTL and testbench

UNIVERSAL_MUX_REGISTER -- requirements
Module: universal_mux_register

---
 rtl/universal_mux_register.sv | 87 ++++++++
 tb/tb_universal_mux_register.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/universal_mux_register.sv
// Universal shift/rotate/load/count register: each Q bit is an edge-triggered cell
// fed by its own 2:1 mux tree selected by mode, then en, then rst.
module universal_mux_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             wrap
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROTR = 3'b100,
    M_ROTL = 3'b101,
    M_UP   = 3'b110,
    M_DOWN = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] nxt;

  assign op  = mode_e'(mode);
  assign inc = Q + WIDTH'(1);
  assign dec = Q - WIDTH'(1);
  assign SOR = Q[0];
  assign SOL = Q[WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic hi_shift, hi_rot, lo_shift, lo_rot;
    logic m_a, m_b, m_c, m_d, m_lo, m_hi, m_op, m_en;

    // The MSB takes its "upper neighbour" from SIR / Q[0]; for WIDTH=1 that makes rotates hold.
    if (i == WIDTH - 1) begin : g_top
      assign hi_shift = SIR;
      assign hi_rot   = Q[0];
    end else begin : g_mid_hi
      assign hi_shift = Q[i+1];
      assign hi_rot   = Q[i+1];
    end

    if (i == 0) begin : g_bottom
      assign lo_shift = SIL;
      assign lo_rot   = Q[WIDTH-1];
    end else begin : g_mid_lo
      assign lo_shift = Q[i-1];
      assign lo_rot   = Q[i-1];
    end

    // Three levels of 2:1 muxes decode mode[0], mode[1], mode[2] in turn.
    assign m_a  = mode[0] ? hi_shift : Q[i];
    assign m_b  = mode[0] ? D[i]     : lo_shift;
    assign m_c  = mode[0] ? lo_rot   : hi_rot;
    assign m_d  = mode[0] ? dec[i]   : inc[i];
    assign m_lo = mode[1] ? m_b      : m_a;
    assign m_hi = mode[1] ? m_d      : m_c;
    assign m_op = mode[2] ? m_hi     : m_lo;
    assign m_en = en      ? m_op     : Q[i];
    assign nxt[i] = rst   ? RESET_VALUE[i] : m_en;
  end

  // Edge-triggered equivalent of the master/slave mux-latch pair: no transparent path D->Q.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every bit samples the pre-edge Q of its neighbours.
    Q <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= en & (((op == M_UP)   && (Q == {WIDTH{1'b1}})) ||
                           ((op == M_DOWN) && (Q == {WIDTH{1'b0}})));
  end

endmodule

// File: tb/tb_universal_mux_register.sv
// Directed bench: vector table for the 8-bit register plus hand sequences for
// enable gating and a 1-bit instance.
module tb_universal_mux_register;

  logic       clk = 1'b0;
  logic       rst, en, sir, sil;
  logic [2:0] mode;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       sor8, sol8, wrap8;
  logic [0:0] d1, q1;
  logic       sor1, sol1, wrap1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  universal_mux_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d8), .SIR(sir), .SIL(sil),
    .Q(q8), .SOR(sor8), .SOL(sol8), .wrap(wrap8)
  );

  universal_mux_register #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(d1), .SIR(sir), .SIL(sil),
    .Q(q1), .SOR(sor1), .SOL(sol1), .wrap(wrap1)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sir;
    logic       sil;
    logic [7:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic add(input string name, input logic r, input logic e, input logic [2:0] m,
                     input logic [7:0] dv, input logic si_r, input logic si_l,
                     input logic [7:0] eq, input logic ew);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.mode = m; v.d = dv;
    v.sir = si_r; v.sil = si_l; v.exp_q = eq; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, take one rising edge, return at the next negedge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic si_r, input logic si_l);
    rst = r; en = e; mode = m; d8 = dv; d1 = dv[0:0]; sir = si_r; sil = si_l;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; d8 = '0; d1 = '0; sir = 1'b0; sil = 1'b0;

    //   name          rst en  mode    D      SIR   SIL   Q      wrap
    add("reset",       1, 0, 3'b000, 8'h00, 0, 0, 8'h00, 0);
    add("load_a5",     0, 1, 3'b011, 8'hA5, 0, 0, 8'hA5, 0);
    add("shr_1",       0, 1, 3'b001, 8'h00, 1, 0, 8'hD2, 0);
    add("shr_2",       0, 1, 3'b001, 8'h00, 1, 0, 8'hE9, 0);
    add("load_81",     0, 1, 3'b011, 8'h81, 0, 0, 8'h81, 0);
    add("rotl",        0, 1, 3'b101, 8'h00, 0, 0, 8'h03, 0);
    add("rotr_1",      0, 1, 3'b100, 8'h00, 0, 0, 8'h81, 0);
    add("rotr_2",      0, 1, 3'b100, 8'h00, 0, 0, 8'hC0, 0);
    add("shl_sil1",    0, 1, 3'b010, 8'h00, 0, 1, 8'h81, 0);
    add("shl_sil0",    0, 1, 3'b010, 8'h00, 1, 0, 8'h02, 0);
    add("load_fe",     0, 1, 3'b011, 8'hFE, 0, 0, 8'hFE, 0);
    add("up_ff",       0, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 0);
    add("up_wrap",     0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 1);
    add("hold_after",  0, 1, 3'b000, 8'h55, 1, 1, 8'h00, 0);
    add("reset_2",     1, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0);
    add("down_wrap",   0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 1);
    add("down_fe",     0, 1, 3'b111, 8'h00, 0, 0, 8'hFE, 0);
    add("load_ff",     0, 1, 3'b011, 8'hFF, 0, 0, 8'hFF, 0);
    add("rst_mid_up",  1, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0);
    add("up_from_rv",  0, 1, 3'b110, 8'h00, 0, 0, 8'h01, 0);
    add("down_to_0",   0, 1, 3'b111, 8'h00, 0, 0, 8'h00, 0);
    add("down_wrap_2", 0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 1);
    add("en0_up_ff",   0, 0, 3'b110, 8'h00, 0, 0, 8'hFF, 0);

    @(negedge clk);
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].mode, vecs[k].d, vecs[k].sir, vecs[k].sil);
      check({vecs[k].name, ".Q"},    q8,    vecs[k].exp_q);
      check({vecs[k].name, ".wrap"}, wrap8, vecs[k].exp_wrap);
      check({vecs[k].name, ".SOR"},  sor8,  vecs[k].exp_q[0]);
      check({vecs[k].name, ".SOL"},  sol8,  vecs[k].exp_q[7]);
    end

    // Enable low holds under every mode, then reset overrides en/load.
    step(1'b0, 1'b1, 3'b011, 8'h3C, 1'b0, 1'b0);
    check("load_3c", q8, 8'h3C);
    for (int m = 0; m < 8; m++) begin
      step(1'b0, 1'b0, m[2:0], 8'hFF, 1'b1, 1'b1);
      check($sformatf("en0_mode%0d.Q", m), q8, 8'h3C);
      check($sformatf("en0_mode%0d.wrap", m), wrap8, 1'b0);
    end
    step(1'b1, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
    check("rst_over_load.Q", q8, 8'h00);
    check("rst_over_load.wrap", wrap8, 1'b0);

    // WIDTH=1 instance, reset value 1.
    step(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    check("w1_reset", q1, 1'b1);
    step(1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b1);
    check("w1_shr_sir0", q1, 1'b0);
    step(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    check("w1_shl_sil1", q1, 1'b1);
    step(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    check("w1_rotr_hold", q1, 1'b1);
    step(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    check("w1_rotl_hold", q1, 1'b1);
    check("w1_sor_sol", {sor1, sol1}, 2'b11);
    step(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    check("w1_up_wrap.Q", q1, 1'b0);
    check("w1_up_wrap.wrap", wrap1, 1'b1);
    step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    check("w1_down_wrap.Q", q1, 1'b1);
    check("w1_down_wrap.wrap", wrap1, 1'b1);
    step(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    check("w1_down_nowrap.Q", q1, 1'b0);
    check("w1_down_nowrap.wrap", wrap1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
